uart_tx_param: RTL and testbench

Parametrised UART transmitter. Successor to the fixed 8N1 transmitter, adding configurable bit period, data width, parity and stop bits, plus a busy/done handshake. Serialises one word per request onto a single tx line, LSB first. Sits between the host-side command logic and the board UART pin.

---
 rtl/uart_tx_param.sv | 174 +++++++++++++++++
 tb/tb_uart_tx_param.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_param.sv
// uart_tx_param: parameterised UART transmitter, LSB first, optional parity, 1 or 2 stop bits.
// Optional line-break generation (brk input) is compiled in when UART_TX_BREAK_EN is defined.
module uart_tx_param #(
  parameter int CLKS_PER_BIT = 5201,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 start,
`ifdef UART_TX_BREAK_EN
  input  logic                 brk,
`endif
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_PRE   = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
    S_PAR     = 3'd3,
    S_STOP    = 3'd4,
    S_BRK     = 3'd5,
    S_BRK_END = 3'd6
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_nxt;
  logic [3:0]             idx_q, idx_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic                   par_q, par_d;
  logic                   tx_d, busy_d, done_d;
  logic                   bit_end;

  // Odd parity inverts the XOR so the total count of ones including the parity bit is odd.
  function automatic logic parity_of(input logic [DATA_BITS-1:0] w);
    return (PARITY == 1) ? ~(^w) : (^w);
  endfunction

  assign bit_end = (cnt_q == CNT_LAST);
  assign cnt_nxt = bit_end ? '0 : cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
`ifdef UART_TX_BREAK_EN
        if (brk) begin
          state_d = S_BRK;
        end else
`endif
        if (start) begin
          state_d = S_START;
          shreg_d = data_in;
          par_d   = parity_of(data_in);
        end
      end
      S_START: begin
        cnt_d = cnt_nxt;
        if (bit_end) begin
          state_d = S_DATA;
          idx_d   = '0;
        end
      end
      S_DATA: begin
        cnt_d = cnt_nxt;
        if (bit_end) begin
          shreg_d = shreg_q >> 1;
          if (idx_q == DATA_LAST) begin
            idx_d   = '0;
            state_d = (PARITY != 0) ? S_PAR : S_STOP;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      S_PAR: begin
        cnt_d = cnt_nxt;
        if (bit_end) begin
          state_d = S_STOP;
          idx_d   = '0;
        end
      end
      S_STOP: begin
        cnt_d = cnt_nxt;
        // done is registered, so raise it one cycle early to land on the final frame cycle
        if (idx_q == STOP_LAST && cnt_q == CNT_PRE) done_d = 1'b1;
        if (bit_end) begin
          if (idx_q == STOP_LAST) begin
            idx_d   = '0;
            state_d = S_IDLE;
            if (start) begin
              state_d = S_START;
              shreg_d = data_in;
              par_d   = parity_of(data_in);
            end
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
`ifdef UART_TX_BREAK_EN
      S_BRK: begin
        cnt_d = '0;
        if (!brk) state_d = S_BRK_END;
      end
      S_BRK_END: begin
        cnt_d = cnt_nxt;
        if (bit_end) state_d = S_IDLE;
      end
`endif
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase

    tx_d   = 1'b1;
    busy_d = 1'b1;
    case (state_d)
      S_IDLE:    busy_d = 1'b0;
      S_START:   tx_d   = 1'b0;
      S_DATA:    tx_d   = shreg_d[0];
      S_PAR:     tx_d   = par_d;
      S_STOP:    tx_d   = 1'b1;
`ifdef UART_TX_BREAK_EN
      S_BRK:     tx_d   = 1'b0;
      S_BRK_END: tx_d   = 1'b1;
`endif
      default:   busy_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      tx      <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      tx      <= tx_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Testbench for uart_tx_param: four configurations, expected line bits queued per frame
// and compared against tx/busy/done every cycle of the frame.
module tb_uart_tx_param;

  localparam int CPB = 16;
  localparam int ND [4] = '{8, 8, 8, 7};
  localparam int PM [4] = '{0, 2, 1, 0};
  localparam int NS [4] = '{1, 1, 1, 2};

  logic       clk = 1'b0;
  logic       reset;
  logic       st  [4];
  logic [7:0] dat [4];
  wire        tx_w   [4];
  wire        busy_w [4];
  wire        done_w [4];
  bit         exp_q [$];
  int         vectors = 0;
  int         miscompares = 0;

  always #5 clk = ~clk;

  uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .reset(reset), .data_in(dat[0]), .start(st[0]),
`ifdef UART_TX_BREAK_EN
    .brk(1'b0),
`endif
    .tx(tx_w[0]), .busy(busy_w[0]), .done(done_w[0]));

  uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u1 (
    .clk(clk), .reset(reset), .data_in(dat[1]), .start(st[1]),
`ifdef UART_TX_BREAK_EN
    .brk(1'b0),
`endif
    .tx(tx_w[1]), .busy(busy_w[1]), .done(done_w[1]));

  uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u2 (
    .clk(clk), .reset(reset), .data_in(dat[2]), .start(st[2]),
`ifdef UART_TX_BREAK_EN
    .brk(1'b0),
`endif
    .tx(tx_w[2]), .busy(busy_w[2]), .done(done_w[2]));

  uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u3 (
    .clk(clk), .reset(reset), .data_in(dat[3][6:0]), .start(st[3]),
`ifdef UART_TX_BREAK_EN
    .brk(1'b0),
`endif
    .tx(tx_w[3]), .busy(busy_w[3]), .done(done_w[3]));

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int flen(input int inst);
    return (1 + ND[inst] + ((PM[inst] != 0) ? 1 : 0) + NS[inst]) * CPB;
  endfunction

  // Expected line bits of one frame: start, data LSB first, parity, stop bits.
  task automatic push_frame(input int inst, input logic [7:0] d);
    int ones = 0;
    exp_q.push_back(1'b0);
    for (int i = 0; i < ND[inst]; i++) begin
      exp_q.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (PM[inst] == 2) exp_q.push_back(ones % 2 == 1);
    else if (PM[inst] == 1) exp_q.push_back(ones % 2 == 0);
    for (int i = 0; i < NS[inst]; i++) exp_q.push_back(1'b1);
  endtask

  // Called at a negedge; returns at the negedge of the first frame cycle.
  task automatic send(input int inst, input logic [7:0] d, input bit hold);
    dat[inst] = d;
    st[inst]  = 1'b1;
    push_frame(inst, dat[inst]);
    @(negedge clk);
    if (!hold) st[inst] = 1'b0;
  endtask

  task automatic check_frame(input int inst, input int ncyc, input int drop_at, input int pulse_at);
    int   fl  = flen(inst);
    logic cur = 1'b1;
    for (int c = 0; c < ncyc; c++) begin
      if (c > 0) @(negedge clk);
      if (c % CPB == 0) begin
        if (exp_q.size() > 0) cur = exp_q.pop_front();
        else cur = 1'bx;
      end
      chk1($sformatf("u%0d tx c%0d", inst, c), tx_w[inst], cur);
      chk1($sformatf("u%0d busy c%0d", inst, c), busy_w[inst], 1'b1);
      chk1($sformatf("u%0d done c%0d", inst, c), done_w[inst], c == fl - 1);
      if (c == drop_at) st[inst] = 1'b0;
      if (pulse_at >= 0 && c == pulse_at) begin
        st[inst]  = 1'b1;
        dat[inst] = 8'hFF;
      end
      if (pulse_at >= 0 && c == pulse_at + 1) st[inst] = 1'b0;
    end
  endtask

  task automatic idle_check(input int inst, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk1($sformatf("u%0d idle tx %0d", inst, i), tx_w[inst], 1'b1);
      chk1($sformatf("u%0d idle busy %0d", inst, i), busy_w[inst], 1'b0);
      chk1($sformatf("u%0d idle done %0d", inst, i), done_w[inst], 1'b0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      st[i]  = 1'b0;
      dat[i] = 8'h00;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk1($sformatf("u%0d rst tx", i), tx_w[i], 1'b1);
      chk1($sformatf("u%0d rst busy", i), busy_w[i], 1'b0);
      chk1($sformatf("u%0d rst done", i), done_w[i], 1'b0);
    end
    reset = 1'b1;
    idle_check(0, 3);

    // 8N1, 0xA5
    send(0, 8'hA5, 1'b0);
    check_frame(0, flen(0), -1, -1);
    chk_int("u0 queue drained", exp_q.size(), 0);
    idle_check(0, 4);

    // even and odd parity, 0xA5
    send(1, 8'hA5, 1'b0);
    check_frame(1, flen(1), -1, -1);
    idle_check(1, 4);
    send(2, 8'hA5, 1'b0);
    check_frame(2, flen(2), -1, -1);
    idle_check(2, 4);

    // 7 data bits, 2 stop bits, 0x41
    send(3, 8'h41, 1'b0);
    check_frame(3, flen(3), -1, -1);
    chk_int("u3 queue drained", exp_q.size(), 0);
    idle_check(3, 4);

    // back-to-back: start held, data changes after the first acceptance
    send(0, 8'h55, 1'b1);
    dat[0] = 8'h0F;
    push_frame(0, dat[0]);
    check_frame(0, flen(0), -1, -1);
    @(negedge clk);
    check_frame(0, flen(0), 0, -1);
    chk_int("u0 b2b queue drained", exp_q.size(), 0);
    idle_check(0, 4);

    // start pulsed with 0xFF in the middle of data bit 3 is ignored
    send(0, 8'hC3, 1'b0);
    check_frame(0, flen(0), -1, 70);
    idle_check(0, 6);

    // asynchronous reset while in DATA
    send(0, 8'h3C, 1'b0);
    check_frame(0, 40, -1, -1);
    #2 reset = 1'b0;
    #1;
    chk1("u0 async rst tx", tx_w[0], 1'b1);
    chk1("u0 async rst busy", busy_w[0], 1'b0);
    chk1("u0 async rst done", done_w[0], 1'b0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    idle_check(0, 20);

    // normal frame after the aborted one
    send(0, 8'h81, 1'b0);
    check_frame(0, flen(0), -1, -1);
    chk_int("u0 post-reset queue drained", exp_q.size(), 0);
    idle_check(0, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
